// File: rtl/mc_reg_file_x_if.sv
// mc_reg_file_x_if: core-side request bus, pin bus and XBus channels of the register file.
// master = core/driver side, slave = register file side.
interface mc_reg_file_x_if #(
   parameter int DATA_W = 11,
   parameter int N_P    = 2,
   parameter int N_X    = 2,
   parameter int ADDR_W = 3
);
   logic                       wr_en;
   logic [ADDR_W-1:0]          wr_addr;
   logic [DATA_W-1:0]          wr_dat;
   logic                       rd_en0, rd_en1;
   logic [ADDR_W-1:0]          rd_addr0, rd_addr1;
   logic [DATA_W-1:0]          dat_out0, dat_out1;
   logic [N_P-1:0][DATA_W-1:0] p_in, p_out;
   logic [N_X-1:0][DATA_W-1:0] x_in_dat, x_out_dat;
   logic [N_X-1:0]             x_in_valid, x_in_ready;
   logic [N_X-1:0]             x_out_valid, x_out_ready;
   logic                       stall;

   modport master (
      output wr_en, wr_addr, wr_dat, rd_en0, rd_en1, rd_addr0, rd_addr1,
      output p_in, x_in_dat, x_in_valid, x_out_ready,
      input  dat_out0, dat_out1, p_out, x_in_ready, x_out_dat, x_out_valid, stall
   );
   modport slave (
      input  wr_en, wr_addr, wr_dat, rd_en0, rd_en1, rd_addr0, rd_addr1,
      input  p_in, x_in_dat, x_in_valid, x_out_ready,
      output dat_out0, dat_out1, p_out, x_in_ready, x_out_dat, x_out_valid, stall
   );
endinterface

// File: rtl/mc_reg_file_x.sv
// mc_reg_file_x: 2R/1W register file (acc, dat, pins, handshaked XBus) with core stall.
// Define MC_SATURATE_EN to clamp every written value to [-999, +999].
module mc_reg_file_x #(
   parameter int DATA_W = 11,
   parameter int N_P    = 2,
   parameter int N_X    = 2,
   parameter int ADDR_W = 3
) (
   input logic            clk,
   input logic            rst_n,
   mc_reg_file_x_if.slave bus
);
   localparam int P_BASE = 2;
   localparam int X_BASE = 2 + N_P;

   typedef enum logic {IDLE, SEND} xst_t;

   logic [DATA_W-1:0]          acc, dat;
   logic [N_P-1:0][DATA_W-1:0] p_q;
   logic [1:0][DATA_W-1:0]     dout;
   logic [1:0]                 re;
   logic [1:0][ADDR_W-1:0]     ra;
   logic [1:0][DATA_W-1:0]     rv;
   logic [1:0][N_P-1:0]        rp;
   logic [1:0][N_X-1:0]        rx;
   logic [N_P-1:0]             wp;
   logic [N_X-1:0]             wx, rx_any, send;
   logic [DATA_W-1:0]          wv;
   logic                       rd_stall, wr_stall, stall;

   assign re = {bus.rd_en1, bus.rd_en0};
   assign ra = {bus.rd_addr1, bus.rd_addr0};

   for (genvar k = 0; k < N_P; k++) begin : g_pdec
      assign wp[k] = bus.wr_en && (bus.wr_addr == ADDR_W'(P_BASE + k));
      for (genvar r = 0; r < 2; r++) begin : g_port
         assign rp[r][k] = re[r] && (ra[r] == ADDR_W'(P_BASE + k));
      end
   end

   for (genvar k = 0; k < N_X; k++) begin : g_xdec
      assign wx[k] = bus.wr_en && (bus.wr_addr == ADDR_W'(X_BASE + k));
      for (genvar r = 0; r < 2; r++) begin : g_port
         assign rx[r][k] = re[r] && (ra[r] == ADDR_W'(X_BASE + k));
      end
   end

   always_comb begin
      for (int r = 0; r < 2; r++) begin
         rv[r] = '0;
         if (ra[r] == ADDR_W'(0)) rv[r] = acc;
         if (ra[r] == ADDR_W'(1)) rv[r] = dat;
         for (int k = 0; k < N_P; k++)
            if (ra[r] == ADDR_W'(P_BASE + k)) rv[r] = bus.p_in[k];
         for (int k = 0; k < N_X; k++)
            if (ra[r] == ADDR_W'(X_BASE + k)) rv[r] = bus.x_in_dat[k];
      end
   end

`ifdef MC_SATURATE_EN
   localparam logic signed [DATA_W-1:0] SAT_HI = DATA_W'(999);
   localparam logic signed [DATA_W-1:0] SAT_LO = DATA_W'(-999);
   always_comb begin
      wv = bus.wr_dat;
      if ($signed(bus.wr_dat) > SAT_HI)      wv = SAT_HI;
      else if ($signed(bus.wr_dat) < SAT_LO) wv = SAT_LO;
   end
`else
   assign wv = bus.wr_dat;
`endif

   // A write to x[k] keeps stalling until the cycle its handshake completes;
   // both ports reading the same x[k] consume a single word.
   assign rx_any   = rx[0] | rx[1];
   assign rd_stall = |(rx_any & ~bus.x_in_valid);
   assign wr_stall = |(wx & ~(send & bus.x_out_ready));
   assign stall    = rd_stall | wr_stall;

   assign bus.stall      = stall;
   assign bus.x_in_ready = stall ? '0 : rx_any;
   assign bus.dat_out0   = dout[0];
   assign bus.dat_out1   = dout[1];
   assign bus.p_out      = p_q;
   assign bus.x_out_valid = send;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc  <= '0;
         dat  <= '0;
         p_q  <= '0;
         dout <= '0;
      end else if (!stall) begin
         for (int r = 0; r < 2; r++)
            if (re[r]) dout[r] <= rv[r];
         if (bus.wr_en && bus.wr_addr == ADDR_W'(0)) acc <= wv;
         if (bus.wr_en && bus.wr_addr == ADDR_W'(1)) dat <= wv;
         for (int k = 0; k < N_P; k++) begin
            if (wp[k])                     p_q[k] <= wv;
            else if (rp[0][k] || rp[1][k]) p_q[k] <= '0;
         end
      end
   end

   for (genvar k = 0; k < N_X; k++) begin : g_xout
      xst_t              st;
      logic [DATA_W-1:0] od;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            st <= IDLE;
            od <= '0;
         end else begin
            case (st)
               IDLE: if (wx[k] && !rd_stall) begin
                  od <= wv;
                  st <= SEND;
               end
               SEND: if (bus.x_out_ready[k]) st <= IDLE;
               default: st <= IDLE;
            endcase
         end
      end

      assign send[k]          = (st == SEND);
      assign bus.x_out_dat[k] = od;
   end
endmodule

// File: tb/tb_mc_reg_file_x.sv
// tb_mc_reg_file_x: directed self-checking bench for mc_reg_file_x (default parameters).
module tb_mc_reg_file_x;
   localparam int W = 11;

   logic clk, rst_n;
   int   n_run, n_fail;

   mc_reg_file_x_if #(.DATA_W(W), .N_P(2), .N_X(2), .ADDR_W(3)) bus ();

   mc_reg_file_x #(.DATA_W(W), .N_P(2), .N_X(2), .ADDR_W(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_wr(input logic [2:0] a, input logic [W-1:0] d);
      bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_dat = d;
      tick();
      bus.wr_en = 1'b0;
   endtask

   task automatic do_rd0(input logic [2:0] a);
      bus.rd_en0 = 1'b1; bus.rd_addr0 = a;
      tick();
      bus.rd_en0 = 1'b0;
   endtask

   task automatic do_rd1(input logic [2:0] a);
      bus.rd_en1 = 1'b1; bus.rd_addr1 = a;
      tick();
      bus.rd_en1 = 1'b0;
   endtask

   task automatic test_reset;
      #3;
      n_run++; if (bus.dat_out0 !== '0) begin n_fail++; $display("FAIL reset_dout0 got %h exp 0", bus.dat_out0); end
      n_run++; if (bus.dat_out1 !== '0) begin n_fail++; $display("FAIL reset_dout1 got %h exp 0", bus.dat_out1); end
      n_run++; if (bus.p_out !== '0) begin n_fail++; $display("FAIL reset_pout got %h exp 0", bus.p_out); end
      n_run++; if (bus.x_out_valid !== 2'b00) begin n_fail++; $display("FAIL reset_xvalid got %b exp 00", bus.x_out_valid); end
      n_run++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", bus.stall); end
      #4 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_acc;
      do_wr(3'd0, W'(5));
      do_rd0(3'd0);
      n_run++; if (bus.dat_out0 !== W'(5)) begin n_fail++; $display("FAIL acc_rd got %0d exp 5", bus.dat_out0); end
      // same-cycle write and read returns the old value
      bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_dat = W'(6);
      bus.rd_en0 = 1'b1; bus.rd_addr0 = 3'd0;
      tick();
      bus.wr_en = 1'b0; bus.rd_en0 = 1'b0;
      n_run++; if (bus.dat_out0 !== W'(5)) begin n_fail++; $display("FAIL acc_rw_old got %0d exp 5", bus.dat_out0); end
      do_rd0(3'd0);
      n_run++; if (bus.dat_out0 !== W'(6)) begin n_fail++; $display("FAIL acc_rw_new got %0d exp 6", bus.dat_out0); end
      do_wr(3'd1, W'(-7));
      do_rd1(3'd1);
      n_run++; if (bus.dat_out1 !== W'(-7)) begin n_fail++; $display("FAIL dat_rd got %h exp %h", bus.dat_out1, W'(-7)); end
      rst_n = 1'b0;
      #1;
      n_run++; if (bus.dat_out0 !== '0) begin n_fail++; $display("FAIL acc_async_rst got %h exp 0", bus.dat_out0); end
      #2 rst_n = 1'b1;
      do_rd0(3'd0);
      n_run++; if (bus.dat_out0 !== '0) begin n_fail++; $display("FAIL acc_after_rst got %h exp 0", bus.dat_out0); end
   endtask

   task automatic test_pins;
      do_wr(3'd2, W'(100));
      n_run++; if (bus.p_out[0] !== W'(100)) begin n_fail++; $display("FAIL pin_wr got %0d exp 100", bus.p_out[0]); end
      bus.p_in[0] = W'(42);
      do_rd0(3'd2);
      n_run++; if (bus.dat_out0 !== W'(42)) begin n_fail++; $display("FAIL pin_rd got %0d exp 42", bus.dat_out0); end
      n_run++; if (bus.p_out[0] !== '0) begin n_fail++; $display("FAIL pin_clr got %0d exp 0", bus.p_out[0]); end
      bus.p_in[0] = W'(11);
      bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_dat = W'(7);
      bus.rd_en1 = 1'b1; bus.rd_addr1 = 3'd2;
      tick();
      bus.wr_en = 1'b0; bus.rd_en1 = 1'b0;
      n_run++; if (bus.p_out[0] !== W'(7)) begin n_fail++; $display("FAIL pin_wr_wins got %0d exp 7", bus.p_out[0]); end
      n_run++; if (bus.dat_out1 !== W'(11)) begin n_fail++; $display("FAIL pin_rd_same got %0d exp 11", bus.dat_out1); end
      do_wr(3'd6, W'(33));
      do_rd0(3'd6);
      n_run++; if (bus.dat_out0 !== '0) begin n_fail++; $display("FAIL null_rd got %0d exp 0", bus.dat_out0); end
   endtask

   task automatic test_xin;
      do_wr(3'd1, W'(123));
      do_rd0(3'd1);
      n_run++; if (bus.dat_out0 !== W'(123)) begin n_fail++; $display("FAIL xin_pre got %0d exp 123", bus.dat_out0); end
      bus.x_in_valid = 2'b00;
      bus.rd_en0 = 1'b1; bus.rd_addr0 = 3'd4;
      bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_dat = W'(321);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_run++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL xin_stall[%0d] got %b exp 1", i, bus.stall); end
         n_run++; if (bus.x_in_ready !== 2'b00) begin n_fail++; $display("FAIL xin_noready[%0d] got %b exp 00", i, bus.x_in_ready); end
         tick();
         n_run++; if (bus.dat_out0 !== W'(123)) begin n_fail++; $display("FAIL xin_hold[%0d] got %0d exp 123", i, bus.dat_out0); end
         n_run++; if (bus.p_out[1] !== '0) begin n_fail++; $display("FAIL xin_pin_frozen[%0d] got %0d exp 0", i, bus.p_out[1]); end
      end
      bus.x_in_valid = 2'b01; bus.x_in_dat[0] = W'(-3);
      #1;
      n_run++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL xin_unstall got %b exp 0", bus.stall); end
      n_run++; if (bus.x_in_ready !== 2'b01) begin n_fail++; $display("FAIL xin_ready got %b exp 01", bus.x_in_ready); end
      tick();
      bus.rd_en0 = 1'b0; bus.wr_en = 1'b0; bus.x_in_valid = 2'b00;
      #1;
      n_run++; if (bus.dat_out0 !== W'(-3)) begin n_fail++; $display("FAIL xin_data got %h exp %h", bus.dat_out0, W'(-3)); end
      n_run++; if (bus.p_out[1] !== W'(321)) begin n_fail++; $display("FAIL xin_pin_late got %0d exp 321", bus.p_out[1]); end
      n_run++; if (bus.x_in_ready !== 2'b00) begin n_fail++; $display("FAIL xin_ready_pulse got %b exp 00", bus.x_in_ready); end
   endtask

   task automatic test_xout;
      bus.x_out_ready = 2'b00;
      bus.wr_en = 1'b1; bus.wr_addr = 3'd5; bus.wr_dat = W'(300);
      #1;
      n_run++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL xout_stall0 got %b exp 1", bus.stall); end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_run++; if (bus.x_out_valid !== 2'b10) begin n_fail++; $display("FAIL xout_valid[%0d] got %b exp 10", i, bus.x_out_valid); end
         n_run++; if (bus.x_out_dat[1] !== W'(300)) begin n_fail++; $display("FAIL xout_dat[%0d] got %0d exp 300", i, bus.x_out_dat[1]); end
         n_run++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL xout_stall[%0d] got %b exp 1", i, bus.stall); end
      end
      bus.x_out_ready = 2'b10;
      #1;
      n_run++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL xout_done_stall got %b exp 0", bus.stall); end
      tick();
      bus.wr_en = 1'b0; bus.x_out_ready = 2'b00;
      n_run++; if (bus.x_out_valid !== 2'b00) begin n_fail++; $display("FAIL xout_idle got %b exp 00", bus.x_out_valid); end
      // a rewrite while SEND is discarded
      bus.wr_en = 1'b1; bus.wr_addr = 3'd5; bus.wr_dat = W'(250);
      tick();
      bus.wr_dat = W'(111);
      tick();
      n_run++; if (bus.x_out_dat[1] !== W'(250)) begin n_fail++; $display("FAIL xout_discard got %0d exp 250", bus.x_out_dat[1]); end
      n_run++; if (bus.x_out_valid !== 2'b10) begin n_fail++; $display("FAIL xout_valid2 got %b exp 10", bus.x_out_valid); end
      rst_n = 1'b0;
      #1;
      n_run++; if (bus.x_out_valid !== 2'b00) begin n_fail++; $display("FAIL xout_rst_valid got %b exp 00", bus.x_out_valid); end
      n_run++; if (bus.x_out_dat[1] !== '0) begin n_fail++; $display("FAIL xout_rst_dat got %0d exp 0", bus.x_out_dat[1]); end
      bus.wr_en = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      n_run++; if (bus.x_out_valid !== 2'b00) begin n_fail++; $display("FAIL xout_post_rst got %b exp 00", bus.x_out_valid); end
      n_run++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL xout_post_rst_stall got %b exp 0", bus.stall); end
   endtask

   task automatic test_sat;
      logic [W-1:0] exp_big;
`ifdef MC_SATURATE_EN
      exp_big = W'(999);
`else
      exp_big = W'(1010);
`endif
      do_wr(3'd0, W'(1500));
      do_rd0(3'd0);
      n_run++; if (bus.dat_out0 !== 11'h5DC) begin n_fail++; $display("FAIL sat_wrap got %h exp 5dc", bus.dat_out0); end
      do_wr(3'd0, W'(1010));
      do_rd0(3'd0);
      n_run++; if (bus.dat_out0 !== exp_big) begin n_fail++; $display("FAIL sat_hi got %0d exp %0d", bus.dat_out0, exp_big); end
      do_wr(3'd0, W'(-5));
      do_rd0(3'd0);
      n_run++; if (bus.dat_out0 !== W'(-5)) begin n_fail++; $display("FAIL sat_neg got %h exp %h", bus.dat_out0, W'(-5)); end
   endtask

   task automatic test_dual_x;
      bus.x_in_valid = 2'b01; bus.x_in_dat[0] = W'(9);
      bus.rd_en0 = 1'b1; bus.rd_addr0 = 3'd4;
      bus.rd_en1 = 1'b1; bus.rd_addr1 = 3'd4;
      #1;
      n_run++; if (bus.x_in_ready !== 2'b01) begin n_fail++; $display("FAIL dual_ready got %b exp 01", bus.x_in_ready); end
      tick();
      bus.rd_en0 = 1'b0; bus.rd_en1 = 1'b0; bus.x_in_valid = 2'b00;
      n_run++; if (bus.dat_out0 !== W'(9)) begin n_fail++; $display("FAIL dual_dout0 got %0d exp 9", bus.dat_out0); end
      n_run++; if (bus.dat_out1 !== W'(9)) begin n_fail++; $display("FAIL dual_dout1 got %0d exp 9", bus.dat_out1); end
   endtask

   initial begin
      n_run = 0; n_fail = 0;
      rst_n = 1'b0;
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_dat = '0;
      bus.rd_en0 = 1'b0; bus.rd_en1 = 1'b0; bus.rd_addr0 = '0; bus.rd_addr1 = '0;
      bus.p_in = '0; bus.x_in_dat = '0; bus.x_in_valid = '0; bus.x_out_ready = '0;
      test_reset();
      test_acc();
      test_pins();
      test_xin();
      test_xout();
      test_sat();
      test_dual_x();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
